// File: rtl/nibble_operand_loader.sv
// nibble_operand_loader: assembles operand A then operand B from a nibble
// stream (least-significant chunk first) and presents the pair to the OR
// unit through a valid/ready handshake. Shadow registers collect the chunks.
// op_a/op_b are loaded only when a pair is complete, so they never show a
// partial load.
module nibble_operand_loader #(
    parameter int WIDTH = 20,
    parameter int NIB   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NIB-1:0]   in_nibble,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b
);

    localparam int NCHUNK = WIDTH / NIB;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t                       state, state_n;
    logic [CW-1:0]                cnt, cnt_n;
    logic [NCHUNK-1:0][NIB-1:0]   shadow_a, shadow_b, b_full;
    logic                         accept, consume, last, commit;

    // The pair is pending exactly while the FSM sits in PRESENT.
    assign out_valid = (state == PRESENT);

    // Handshake decode and next-state; clear overrides any transfer.
    always_comb begin
        in_ready = (state != PRESENT);
        accept   = in_valid && in_ready && !clear;
        consume  = out_valid && out_ready && !clear;
        last     = (cnt == LAST);
        commit   = accept && last && (state == LOAD_B);
        state_n  = state;
        cnt_n    = cnt;
        // B as it will look including the chunk accepted on the commit edge
        b_full             = shadow_b;
        b_full[NCHUNK-1]   = in_nibble;
        if (clear) begin
            state_n = LOAD_A;
            cnt_n   = '0;
        end else begin
            case (state)
                LOAD_A: if (accept) begin
                    if (last) begin
                        cnt_n   = '0;
                        state_n = LOAD_B;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                LOAD_B: if (accept) begin
                    if (last) begin
                        cnt_n   = '0;
                        state_n = PRESENT;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                PRESENT: if (consume) state_n = LOAD_A;
                default: begin
                    state_n = LOAD_A;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // State, chunk counter and committed output pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (commit) begin
                op_a <= shadow_a;
                op_b <= b_full;
            end
        end
    end

    // Shadow capture: the accepted chunk lands in the slot selected by cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_a <= '0;
            shadow_b <= '0;
        end else if (accept) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (cnt == CW'(k)) begin
                    if (state == LOAD_A) shadow_a[k] <= in_nibble;
                    if (state == LOAD_B) shadow_b[k] <= in_nibble;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_operand_loader.sv
// Bench for nibble_operand_loader: directed scenarios plus randomized pairs,
// checked against a pair-level model (expected committed A/B values).
module tb_nibble_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_nibble = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] op_a, op_b;

    int total = 0;
    int bad = 0;
    logic [19:0] exp_a = '0;
    logic [19:0] exp_b = '0;

    nibble_operand_loader #(.WIDTH(20), .NIB(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_nibble(in_nibble),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [3:0] n);
        in_valid  = 1'b1;
        in_nibble = n;
        step();
        in_valid  = 1'b0;
    endtask

    // Stream the ten chunks of A then B; mode 0 = every cycle, 1 = toggle, 2 = random gaps.
    task automatic load_pair(input logic [19:0] a, input logic [19:0] b, input int mode);
        logic [3:0] ch[$];
        int acc, cyc;
        logic rdy;
        ch = {};
        for (int k = 0; k < 5; k++) ch.push_back(a[4*k +: 4]);
        for (int k = 0; k < 5; k++) ch.push_back(b[4*k +: 4]);
        acc = 0;
        cyc = 0;
        while (acc < 10 && cyc < 200) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 99) >= 30);
            endcase
            in_nibble = in_valid ? ch[acc] : 4'($urandom);
            rdy = in_ready;
            total++;
            if (rdy !== 1'b1) begin
                bad++;
                $display("FAIL load_in_ready: got %b want 1 (chunk %0d)", rdy, acc);
            end
            @(posedge clk);
            if (in_valid && rdy) acc++;
            #1;
            cyc++;
            if (acc < 10) begin
                total++;
                if (out_valid !== 1'b0 || op_a !== exp_a || op_b !== exp_b) begin
                    bad++;
                    $display("FAIL load_hold: out_valid=%b op_a=%h op_b=%h want 0 %h %h",
                             out_valid, op_a, op_b, exp_a, exp_b);
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (acc != 10) begin
            bad++;
            $display("FAIL load_timeout: accepted %0d want 10", acc);
        end
        total++;
        if (out_valid !== 1'b1 || op_a !== a || op_b !== b) begin
            bad++;
            $display("FAIL commit: out_valid=%b op_a=%h op_b=%h want 1 %h %h",
                     out_valid, op_a, op_b, a, b);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL present_in_ready: got %b want 0", in_ready);
        end
        exp_a = a;
        exp_b = b;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_a !== exp_a || op_b !== exp_b) begin
            bad++;
            $display("FAIL consume: out_valid=%b in_ready=%b op_a=%h op_b=%h want 0 1 %h %h",
                     out_valid, in_ready, op_a, op_b, exp_a, exp_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if (op_a !== 20'h0 || op_b !== 20'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_hold: op_a=%h op_b=%h out_valid=%b in_ready=%b want 0 0 0 1",
                     op_a, op_b, out_valid, in_ready);
        end
        #2 rst_n = 1'b1;
        step();
        total++;
        if (op_a !== 20'h0 || op_b !== 20'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: op_a=%h op_b=%h out_valid=%b in_ready=%b want 0 0 0 1",
                     op_a, op_b, out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [19:0] or_out;
        out_ready = 1'b1;
        load_pair(20'h12345, 20'hABCDE, 0);
        or_out = op_a | op_b;
        total++;
        if (or_out !== 20'hBBFDF) begin
            bad++;
            $display("FAIL basic_or: got %h want bbfdf", or_out);
        end
        // out_ready already high: the pair is consumed on the next edge
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || op_a !== 20'h12345 || op_b !== 20'hABCDE) begin
            bad++;
            $display("FAIL basic_consume: out_valid=%b op_a=%h op_b=%h want 0 12345 abcde",
                     out_valid, op_a, op_b);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        load_pair(20'($urandom), 20'($urandom), 0);
        for (int i = 0; i < 7; i++) begin
            in_valid  = 1'b1;
            in_nibble = 4'($urandom);
            step();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || op_a !== exp_a || op_b !== exp_b) begin
                bad++;
                $display("FAIL backpressure_%0d: out_valid=%b in_ready=%b op_a=%h op_b=%h want 1 0 %h %h",
                         i, out_valid, in_ready, op_a, op_b, exp_a, exp_b);
            end
        end
        in_valid = 1'b0;
        consume();
    endtask

    task automatic test_gaps();
        load_pair(20'h12345, 20'hABCDE, 1);
        consume();
    endtask

    task automatic test_abort();
        for (int k = 0; k < 5; k++) feed(4'h7);
        for (int k = 0; k < 3; k++) feed(4'h9);
        clear     = 1'b1;
        in_valid  = 1'b1;
        in_nibble = 4'h6;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_a !== exp_a || op_b !== exp_b) begin
            bad++;
            $display("FAIL abort_hold: out_valid=%b in_ready=%b op_a=%h op_b=%h want 0 1 %h %h",
                     out_valid, in_ready, op_a, op_b, exp_a, exp_b);
        end
        load_pair(20'hFFFFF, 20'h00001, 0);
        // clear while presenting drops the pair but keeps the registers
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++;
        if (out_valid !== 1'b0 || op_a !== 20'hFFFFF || op_b !== 20'h00001) begin
            bad++;
            $display("FAIL clear_present: out_valid=%b op_a=%h op_b=%h want 0 fffff 00001",
                     out_valid, op_a, op_b);
        end
        load_pair(20'h2468A, 20'h13579, 0);
        consume();
    endtask

    task automatic test_async_reset();
        load_pair(20'($urandom), 20'($urandom), 0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (op_a !== 20'h0 || op_b !== 20'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_present: op_a=%h op_b=%h out_valid=%b in_ready=%b want 0 0 0 1",
                     op_a, op_b, out_valid, in_ready);
        end
        exp_a = '0;
        exp_b = '0;
        #1 rst_n = 1'b1;
        step();
        feed(4'hC);
        feed(4'h3);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (op_a !== 20'h0 || op_b !== 20'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_load_a: op_a=%h op_b=%h out_valid=%b in_ready=%b want 0 0 0 1",
                     op_a, op_b, out_valid, in_ready);
        end
        #1 rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        load_pair(20'h12345, 20'hABCDE, 0);
        consume();
    endtask

    task automatic test_random();
        logic [19:0] a, b;
        int bp;
        for (int n = 0; n < 8; n++) begin
            a = 20'($urandom);
            b = 20'($urandom);
            load_pair(a, b, 2);
            bp = $urandom_range(0, 4);
            for (int i = 0; i < bp; i++) begin
                in_valid  = 1'($urandom);
                in_nibble = 4'($urandom);
                step();
                total++;
                if (out_valid !== 1'b1 || op_a !== a || op_b !== b) begin
                    bad++;
                    $display("FAIL random_hold_%0d: out_valid=%b op_a=%h op_b=%h want 1 %h %h",
                             n, out_valid, op_a, op_b, a, b);
                end
            end
            in_valid = 1'b0;
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
